branch_scheduler: RTL and testbench

Sequencing controller for the shared branch comparator in the decode stage. Accepts one branch request at a time and holds it while its operands are still in flight from later stages, capturing them off the forwarding bus. When both operands are valid, it drives the comparator for one cycle and registers the result. It then issues a single resolve pulse with taken/not-taken and the next PC, and stalls the front end until that pulse.

---
 rtl/branch_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_branch_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_scheduler.sv
// branch_scheduler: holds one branch in the decode stage until both of its
// operands are available, drives the shared comparator for one cycle, then
// issues a single resolve pulse with the outcome and the next PC.
module branch_scheduler (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [2:0]  ReqOp,
  input  logic [31:0] ReqA,
  input  logic [31:0] ReqB,
  input  logic        ReqAPend,
  input  logic        ReqBPend,
  input  logic [4:0]  ReqATag,
  input  logic [4:0]  ReqBTag,
  input  logic [31:0] ReqTarget,
  input  logic [31:0] ReqPcNext,
  input  logic        FwdValid,
  input  logic [4:0]  FwdTag,
  input  logic [31:0] FwdData,
  input  logic        Flush,
  output logic [31:0] CmpInA,
  output logic [31:0] CmpInB,
  output logic [2:0]  CmpControl,
  input  logic        CmpResult,
  output logic        Stall,
  output logic        ResolveValid,
  output logic        Taken,
  output logic [31:0] NextPc,
  output logic        IllegalOp,
  output logic [15:0] StallCount
);

  localparam logic [2:0] OP_BGEZ = 3'b001;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT, CMP, DONE} state_t;

  state_t      state;

  // Latched request
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        apend_q, bpend_q;
  logic [4:0]  atag_q, btag_q;
  logic [31:0] tgt_q, pcn_q;

  // Registered outputs
  logic [31:0] cmp_a_q, cmp_b_q;
  logic [2:0]  cmp_ctl_q;
  logic        taken_q;
  logic [31:0] npc_q;
  logic [15:0] stall_cnt_q;

  // Operand view for this cycle (request inputs in IDLE, latched copy otherwise)
  logic [2:0]  src_op;
  logic [31:0] src_a, src_b;
  logic        src_apend, src_bpend;
  logic [4:0]  src_atag, src_btag;

  // Operands after applying this cycle's forwarding bus
  logic [31:0] nxt_a, nxt_b;
  logic        nxt_apend, nxt_bpend;
  logic        operands_ready;

  // Comparator drive derived from the operands
  logic [31:0] sub_b;
  logic [2:0]  sub_ctl;

  logic        resolve_taken;

  // Select operand source, apply forwarding and zero-operand substitution
  always_comb begin
    if (state == IDLE) begin
      src_op    = ReqOp;
      src_atag  = ReqATag;
      src_btag  = ReqBTag;
      // Register 0 is never in flight: a "pending" r0 reads as zero at accept.
      src_apend = ReqAPend && (ReqATag != '0);
      src_bpend = ReqBPend && (ReqBTag != '0);
      src_a     = (ReqAPend && (ReqATag == '0)) ? '0 : ReqA;
      src_b     = (ReqBPend && (ReqBTag == '0)) ? '0 : ReqB;
    end else begin
      src_op    = op_q;
      src_atag  = atag_q;
      src_btag  = btag_q;
      src_apend = apend_q;
      src_bpend = bpend_q;
      src_a     = a_q;
      src_b     = b_q;
    end

    nxt_a     = src_a;
    nxt_apend = src_apend;
    if (src_apend && FwdValid && (FwdTag == src_atag)) begin
      nxt_a     = FwdData;
      nxt_apend = 1'b0;
    end

    nxt_b     = src_b;
    nxt_bpend = src_bpend;
    if (src_bpend && FwdValid && (FwdTag == src_btag)) begin
      nxt_b     = FwdData;
      nxt_bpend = 1'b0;
    end

    operands_ready = !nxt_apend && !nxt_bpend;

    // Sign tests against zero reuse comparator code 001 with a constant B.
    sub_b   = nxt_b;
    sub_ctl = src_op;
    case (src_op)
      OP_BGEZ: begin
        sub_b   = 32'd1;
        sub_ctl = 3'b001;
      end
      OP_BLTZ: begin
        sub_b   = '0;
        sub_ctl = 3'b001;
      end
      OP_ILL:  sub_ctl = '0;
      default: ;
    endcase

    resolve_taken = (op_q != OP_ILL) && CmpResult;
  end

  // Sequencing FSM, operand capture, result registers and WAIT-cycle counter
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      apend_q     <= 1'b0;
      bpend_q     <= 1'b0;
      atag_q      <= '0;
      btag_q      <= '0;
      tgt_q       <= '0;
      pcn_q       <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_ctl_q   <= '0;
      taken_q     <= 1'b0;
      npc_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((state == WAIT) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 16'd1;

      if (Flush) begin
        state   <= IDLE;
        apend_q <= 1'b0;
        bpend_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ReqValid) begin
              op_q    <= ReqOp;
              atag_q  <= ReqATag;
              btag_q  <= ReqBTag;
              tgt_q   <= ReqTarget;
              pcn_q   <= ReqPcNext;
              a_q     <= nxt_a;
              b_q     <= nxt_b;
              apend_q <= nxt_apend;
              bpend_q <= nxt_bpend;
              if (operands_ready) begin
                state     <= CMP;
                cmp_a_q   <= nxt_a;
                cmp_b_q   <= sub_b;
                cmp_ctl_q <= sub_ctl;
              end else begin
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            a_q     <= nxt_a;
            b_q     <= nxt_b;
            apend_q <= nxt_apend;
            bpend_q <= nxt_bpend;
            if (operands_ready) begin
              state     <= CMP;
              cmp_a_q   <= nxt_a;
              cmp_b_q   <= sub_b;
              cmp_ctl_q <= sub_ctl;
            end
          end
          CMP: begin
            taken_q <= resolve_taken;
            npc_q   <= resolve_taken ? tgt_q : pcn_q;
            state   <= DONE;
          end
          DONE: state <= IDLE;
        endcase
      end
    end
  end

  // Handshake and status outputs; ReqReady stays low while reset is asserted
  assign ReqReady     = Reset && (state == IDLE) && !Flush;
  assign Stall        = (state != IDLE);
  assign ResolveValid = (state == DONE) && !Flush;
  assign IllegalOp    = ResolveValid && (op_q == OP_ILL);
  assign CmpInA       = cmp_a_q;
  assign CmpInB       = cmp_b_q;
  assign CmpControl   = cmp_ctl_q;
  assign Taken        = taken_q;
  assign NextPc       = npc_q;
  assign StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_branch_scheduler.sv
// Bench for branch_scheduler: directed branch requests against a
// transaction-level model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_branch_scheduler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [2:0]  ReqOp = '0;
  logic [31:0] ReqA = '0, ReqB = '0;
  logic        ReqAPend = 1'b0, ReqBPend = 1'b0;
  logic [4:0]  ReqATag = '0, ReqBTag = '0;
  logic [31:0] ReqTarget = '0, ReqPcNext = '0;
  logic        FwdValid = 1'b0;
  logic [4:0]  FwdTag = '0;
  logic [31:0] FwdData = '0;
  logic        Flush = 1'b0;
  logic [31:0] CmpInA, CmpInB;
  logic [2:0]  CmpControl;
  logic        CmpResult;
  logic        Stall, ResolveValid, Taken, IllegalOp;
  logic [31:0] NextPc;
  logic [15:0] StallCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  branch_scheduler dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB), .ReqAPend(ReqAPend), .ReqBPend(ReqBPend),
    .ReqATag(ReqATag), .ReqBTag(ReqBTag), .ReqTarget(ReqTarget), .ReqPcNext(ReqPcNext),
    .FwdValid(FwdValid), .FwdTag(FwdTag), .FwdData(FwdData), .Flush(Flush),
    .CmpInA(CmpInA), .CmpInB(CmpInB), .CmpControl(CmpControl), .CmpResult(CmpResult),
    .Stall(Stall), .ResolveValid(ResolveValid), .Taken(Taken), .NextPc(NextPc),
    .IllegalOp(IllegalOp), .StallCount(StallCount)
  );

  // Shared comparator: 001 is a sign test whose sense is picked by B[0]
  function automatic logic comparator(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] c);
    case (c)
      3'b000:  return a == b;
      3'b001:  return a[31] ^ b[0];
      3'b010:  return $signed(a) > 32'sd0;
      3'b011:  return $signed(a) <= 32'sd0;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return a != b;
      3'b110:  return $signed(a) > $signed(b);
      default: return 1'b0;
    endcase
  endfunction

  always_comb CmpResult = comparator(CmpInA, CmpInB, CmpControl);

  // Architectural branch outcome by mnemonic
  function automatic logic branch_taken(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd0:    return a == b;
      3'd1:    return $signed(a) >= 32'sd0;
      3'd2:    return $signed(a) > 32'sd0;
      3'd3:    return $signed(a) <= 32'sd0;
      3'd4:    return $signed(a) < 32'sd0;
      3'd5:    return a != b;
      3'd6:    return $signed(a) > $signed(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 operands outstanding, 2 comparing, 3 resolving
  int          ph = 0;
  logic [2:0]  mop = '0;
  logic [31:0] ma = '0, mb = '0, mtgt = '0, mpcn = '0;
  logic        mpa = 1'b0, mpb = 1'b0;
  logic [4:0]  mta = '0, mtb = '0;
  logic        m_taken = 1'b0;
  logic [31:0] m_npc = '0, m_cia = '0, m_cib = '0;
  logic [2:0]  m_cc = '0;
  int unsigned m_sc = 0;

  task automatic model_fwd();
    if (mpa && FwdValid && FwdTag == mta) begin ma = FwdData; mpa = 1'b0; end
    if (mpb && FwdValid && FwdTag == mtb) begin mb = FwdData; mpb = 1'b0; end
  endtask

  task automatic model_drive();
    m_cia = ma;
    m_cib = (mop == 3'd1) ? 32'd1 : (mop == 3'd4) ? 32'd0 : mb;
    m_cc  = (mop == 3'd1 || mop == 3'd4) ? 3'd1 : (mop == 3'd7) ? 3'd0 : mop;
  endtask

  // Advance one clock edge and update the model from the inputs it saw
  task automatic adv();
    @(posedge Clock);
    if (!Reset) begin
      ph = 0; m_taken = 1'b0; m_npc = '0; m_cia = '0; m_cib = '0; m_cc = '0;
      m_sc = 0; mpa = 1'b0; mpb = 1'b0;
    end else begin
      if (ph == 1 && m_sc < 65535) m_sc++;
      if (Flush) ph = 0;
      else if (ph == 0) begin
        if (ReqValid) begin
          mop = ReqOp; mtgt = ReqTarget; mpcn = ReqPcNext; mta = ReqATag; mtb = ReqBTag;
          ma = ReqA; mpa = ReqAPend; mb = ReqB; mpb = ReqBPend;
          if (mpa && ReqATag == 5'd0) begin mpa = 1'b0; ma = '0; end
          if (mpb && ReqBTag == 5'd0) begin mpb = 1'b0; mb = '0; end
          model_fwd();
          if (mpa || mpb) ph = 1;
          else begin ph = 2; model_drive(); end
        end
      end else if (ph == 1) begin
        model_fwd();
        if (!mpa && !mpb) begin ph = 2; model_drive(); end
      end else if (ph == 2) begin
        m_taken = branch_taken(mop, ma, mb);
        m_npc   = m_taken ? mtgt : mpcn;
        ph = 3;
      end else ph = 0;
    end
    #1;
  endtask

  // Compare every DUT output with the model on the falling edge
  task automatic look();
    @(negedge Clock);
    chk1("ReqReady", ReqReady, Reset && (ph == 0) && !Flush);
    chk1("Stall", Stall, ph != 0);
    chk1("ResolveValid", ResolveValid, (ph == 3) && !Flush);
    chk1("IllegalOp", IllegalOp, (ph == 3) && !Flush && (mop == 3'd7));
    chk1("Taken", Taken, m_taken);
    chk32("NextPc", NextPc, m_npc);
    chk32("StallCount", {16'd0, StallCount}, m_sc);
    chk32("CmpInA", CmpInA, m_cia);
    chk32("CmpInB", CmpInB, m_cib);
    chk32("CmpControl", {29'd0, CmpControl}, {29'd0, m_cc});
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ap, input logic bp, input logic [4:0] at,
                      input logic [4:0] bt, input logic [31:0] tgt, input logic [31:0] pcn);
    ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b; ReqAPend = ap; ReqBPend = bp;
    ReqATag = at; ReqBTag = bt; ReqTarget = tgt; ReqPcNext = pcn;
    look();
    chk1("accept_ready", ReqReady, 1'b1);
    adv();
    ReqValid = 1'b0;
  endtask

  // Step until the resolve pulse (bounded) and pin its literal values
  task automatic run_to_resolve(input string name, input logic tk, input logic [31:0] npc,
                                input logic ill, input int exp_lat);
    int lat = 0;
    bit done = 1'b0;
    while (!done) begin
      look();
      if (ResolveValid) begin
        chk1({name, "_taken"}, Taken, tk);
        chk32({name, "_nextpc"}, NextPc, npc);
        chk1({name, "_illegal"}, IllegalOp, ill);
        chk32({name, "_latency"}, lat, exp_lat);
        done = 1'b1;
      end else if (lat >= 8) begin
        chk1({name, "_resolve_timeout"}, ResolveValid, 1'b1);
        done = 1'b1;
      end
      adv();
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, inb;
    logic [2:0]  cc;
    logic        tk;
  } vec_t;

  vec_t vecs [10] = '{
    '{3'd0, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 3'd0, 1'b1},
    '{3'd2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3'd2, 1'b0},
    '{3'd3, 32'h0000_0000, 32'h0000_0007, 32'h0000_0007, 3'd3, 1'b1},
    '{3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 3'd6, 1'b0},
    '{3'd6, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 3'd6, 1'b1},
    '{3'd5, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002, 3'd5, 1'b1},
    '{3'd4, 32'hFFFF_FFFF, 32'h0000_0009, 32'h0000_0000, 3'd1, 1'b1},
    '{3'd1, 32'h0000_0000, 32'h0000_0009, 32'h0000_0001, 3'd1, 1'b1},
    '{3'd7, 32'h0000_0005, 32'h0000_0005, 32'h0000_0005, 3'd0, 1'b0},
    '{3'd1, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 3'd1, 1'b0}
  };

  initial begin
    logic [31:0] tgt, pcn;

    // Reset
    Reset = 1'b0;
    adv();
    look();
    chk1("rst_ready", ReqReady, 1'b0);
    chk1("rst_stall", Stall, 1'b0);
    chk32("rst_stallcount", {16'd0, StallCount}, 32'd0);
    chk32("rst_nextpc", NextPc, 32'd0);
    adv();
    Reset = 1'b1;
    look();
    adv();

    // Ready operands: every opcode, substitution and illegal handling
    for (int i = 0; i < 10; i++) begin
      tgt = 32'h400 + 32'(i * 16);
      pcn = 32'h104 + 32'(i * 16);
      send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 5'd1, 5'd2, tgt, pcn);
      look();
      chk32($sformatf("vec%0d_cmp_a", i), CmpInA, vecs[i].a);
      chk32($sformatf("vec%0d_cmp_b", i), CmpInB, vecs[i].inb);
      chk32($sformatf("vec%0d_cmp_ctl", i), {29'd0, CmpControl}, {29'd0, vecs[i].cc});
      adv();
      run_to_resolve($sformatf("vec%0d", i), vecs[i].tk, vecs[i].tk ? tgt : pcn,
                     vecs[i].op == 3'd7, 0);
    end
    chk32("ready_stallcount", {16'd0, StallCount}, 32'd0);

    // Forwarded operand after three WAIT cycles; first beat carries a foreign tag
    send(3'd5, 32'h0, 32'h7, 1'b1, 1'b0, 5'd5, 5'd2, 32'h800, 32'h204);
    FwdValid = 1'b1; FwdTag = 5'd6; FwdData = 32'd99;
    look(); adv();
    FwdValid = 1'b0;
    look(); adv();
    FwdValid = 1'b1; FwdTag = 5'd5; FwdData = 32'd7;
    look(); adv();
    FwdValid = 1'b0;
    look();
    chk32("fwd_cmp_a", CmpInA, 32'd7);
    adv();
    run_to_resolve("fwd", 1'b0, 32'h204, 1'b0, 0);
    chk32("fwd_stallcount", {16'd0, StallCount}, 32'd3);

    // Flush in IDLE blocks acceptance
    ReqValid = 1'b1; ReqOp = 3'd0; ReqA = 32'd1; ReqB = 32'd1;
    ReqAPend = 1'b0; ReqBPend = 1'b0; Flush = 1'b1;
    look();
    chk1("flush_idle_ready", ReqReady, 1'b0);
    adv();
    ReqValid = 1'b0; Flush = 1'b0;
    look();
    chk1("flush_idle_no_accept", Stall, 1'b0);
    adv();

    // Flush after two WAIT cycles, then a fresh BGTZ
    send(3'd0, 32'h0, 32'h1, 1'b1, 1'b0, 5'd9, 5'd2, 32'h900, 32'h300);
    look(); adv();
    look(); adv();
    Flush = 1'b1;
    look();
    chk1("flush_wait_resolve", ResolveValid, 1'b0);
    adv();
    Flush = 1'b0;
    look();
    chk1("flush_stall_low", Stall, 1'b0);
    chk32("flush_stallcount", {16'd0, StallCount}, 32'd6);
    adv();
    send(3'd2, 32'd5, 32'd3, 1'b0, 1'b0, 5'd1, 5'd2, 32'hA00, 32'h400);
    look(); adv();
    run_to_resolve("bgtz", 1'b1, 32'hA00, 1'b0, 0);

    // Pending on tag 0 reads zero and skips WAIT
    send(3'd0, 32'hDEAD, 32'h0, 1'b1, 1'b0, 5'd0, 5'd2, 32'hB00, 32'h500);
    look();
    chk32("tag0_cmp_a", CmpInA, 32'd0);
    adv();
    run_to_resolve("tag0", 1'b1, 32'hB00, 1'b0, 0);

    // Forwarding in the accept cycle counts as available
    FwdValid = 1'b1; FwdTag = 5'd3; FwdData = 32'd4;
    send(3'd5, 32'h0, 32'h4, 1'b1, 1'b0, 5'd3, 5'd2, 32'hC00, 32'h600);
    FwdValid = 1'b0;
    look();
    chk32("fwd_accept_cmp_a", CmpInA, 32'd4);
    adv();
    run_to_resolve("fwd_accept", 1'b0, 32'h600, 1'b0, 0);

    // One forward clears both operands sharing a tag
    send(3'd6, 32'h0, 32'h0, 1'b1, 1'b1, 5'd7, 5'd7, 32'hD00, 32'h700);
    FwdValid = 1'b1; FwdTag = 5'd7; FwdData = 32'h55;
    look(); adv();
    FwdValid = 1'b0;
    look();
    chk32("both_cmp_a", CmpInA, 32'h55);
    chk32("both_cmp_b", CmpInB, 32'h55);
    adv();
    run_to_resolve("both_tag", 1'b0, 32'h700, 1'b0, 0);
    chk32("both_stallcount", {16'd0, StallCount}, 32'd7);

    // Long WAIT saturates the counter, then reset mid-WAIT
    send(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd12, 5'd2, 32'hE00, 32'h800);
    for (int i = 0; i < 70000; i++) begin
      look(); adv();
    end
    look();
    chk32("sat_stallcount", {16'd0, StallCount}, 32'h0000_FFFF);
    chk1("sat_stall", Stall, 1'b1);
    Reset = 1'b0;
    adv();
    look();
    chk1("mid_rst_ready", ReqReady, 1'b0);
    chk1("mid_rst_stall", Stall, 1'b0);
    chk1("mid_rst_resolve", ResolveValid, 1'b0);
    chk1("mid_rst_taken", Taken, 1'b0);
    chk1("mid_rst_illegal", IllegalOp, 1'b0);
    chk32("mid_rst_nextpc", NextPc, 32'd0);
    chk32("mid_rst_cmp_a", CmpInA, 32'd0);
    chk32("mid_rst_cmp_b", CmpInB, 32'd0);
    chk32("mid_rst_cmp_ctl", {29'd0, CmpControl}, 32'd0);
    chk32("mid_rst_stallcount", {16'd0, StallCount}, 32'd0);
    Reset = 1'b1;
    adv();
    look();
    chk1("post_rst_ready", ReqReady, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
